// File: rtl/capture_sched.sv
// Ping-pong capture scheduler: steers the ADC capture engine into a free sample-RAM bank
// and hands completed banks to one consumer. Define CAP_TIMEOUT_EN to add a capture watchdog.
module capture_sched #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             single,
  output logic             cap_start,
  input  logic             cap_done,
  output logic             wr_bank,
  input  logic             rd_req,
  output logic             rd_grant,
  output logic             rd_bank,
  input  logic             rd_done,
  output logic [1:0]       full,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             overrun,
  output logic             timeout_err
);

  typedef enum logic [2:0] {IDLE, ARM, CAPTURE, RELEASE, STALL} state_t;

  state_t     state, state_nxt;
  logic [1:0] full_nxt;
  logic       last_wr;
  logic       pend_single;
  logic       cap_set, rd_clr;
  logic       bank_tgl, ovr_set, pend_set, pend_clr;
  logic       tmo_hit;

  assign cap_set   = (state == CAPTURE) && cap_done;
  assign rd_clr    = rd_grant && rd_done;
  assign cap_start = (state == CAPTURE);
  assign busy      = (state != IDLE);

  // Set and clear target different banks by construction, so both may apply together.
  always_comb begin
    full_nxt = full;
    if (cap_set) full_nxt[wr_bank] = 1'b1;
    if (rd_clr)  full_nxt[rd_bank] = 1'b0;
  end

`ifdef CAP_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == CAPTURE) && !cap_done && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == CAPTURE) ? tmo_cnt + TMO_W'(1) : '0;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
  // Parameter kept so instantiations stay identical whether or not the watchdog is built.
  if (TIMEOUT_CYC == 0) begin : g_tmo_unused
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bank_tgl  = 1'b0;
    ovr_set   = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (run || single) begin
          state_nxt = ARM;
          pend_set  = single;
        end
      end
      ARM:     state_nxt = full[wr_bank] ? STALL : CAPTURE;
      CAPTURE: if (cap_done || tmo_hit) state_nxt = RELEASE;
      RELEASE: begin
        if (!cap_done) begin
          bank_tgl = 1'b1;
          if (run) begin
            state_nxt = ARM;
          end else begin
            state_nxt = IDLE;
            pend_clr  = 1'b1;
          end
        end
      end
      STALL: begin
        ovr_set = run;
        // Look at the post-release flags so a same-cycle rd_done re-arms immediately.
        if (!full_nxt[wr_bank])          state_nxt = ARM;
        else if (!run && !pend_single)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full        <= '0;
      frame_cnt   <= '0;
      last_wr     <= 1'b0;
      wr_bank     <= 1'b0;
      overrun     <= 1'b0;
      pend_single <= 1'b0;
      rd_grant    <= 1'b0;
      rd_bank     <= 1'b0;
    end else begin
      full <= full_nxt;
      if (cap_set) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        last_wr   <= wr_bank;
      end
      if (bank_tgl) wr_bank <= ~wr_bank;
      if (ovr_set)  overrun <= 1'b1;
      if (pend_clr)      pend_single <= 1'b0;
      else if (pend_set) pend_single <= 1'b1;
      if (rd_grant) begin
        if (rd_done) rd_grant <= 1'b0;
      end else if (rd_req && (|full)) begin
        rd_grant <= 1'b1;
        // Oldest full bank: with both full it is the one not written last.
        rd_bank  <= (full == 2'b11) ? ~last_wr : full[1];
      end
    end
  end

endmodule
